// File: rtl/stream_mux_rr.sv
// N-to-1 stream multiplexer with round-robin grant and a single registered output stage.
// Define STREAM_MUX_FIXED_PRIO_EN to replace round-robin with fixed priority (lowest index wins).
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  input  logic                 out_ready
);

  logic             load_en;
  logic             gnt_found;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic             in_xfer;

  assign load_en = !out_valid || out_ready;
  assign in_xfer = load_en && gnt_found;

`ifdef STREAM_MUX_FIXED_PRIO_EN
  always_comb begin
    gnt_found = |in_valid;
    gnt_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (in_valid[k]) gnt_idx = SEL_W'(k);
    end
  end
`else
  logic [SEL_W-1:0] last_q;
  logic [SEL_W-1:0] cand;

  // Walk the channels starting one past the last winner, wrapping at N-1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = last_q;
    for (int k = 0; k < N; k++) begin
      cand = (cand == SEL_W'(N - 1)) ? '0 : cand + SEL_W'(1);
      if (!gnt_found && in_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // The pointer only advances on an actual transfer, so a channel that
  // withdraws its valid never costs anyone a turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= SEL_W'(N - 1);
    end else if (in_xfer) begin
      last_q <= gnt_idx;
    end
  end
`endif

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_idx == SEL_W'(k)) gnt_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // rst_n gates ready so nothing is accepted while the output register is held cleared.
  always_comb begin
    in_ready = '0;
    if (rst_n && in_xfer) in_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load_en) begin
      out_valid <= gnt_found;
      if (gnt_found) begin
        out_data <= gnt_data;
        out_sel  <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr with a transaction-level reference model checked every cycle.
// Honours STREAM_MUX_FIXED_PRIO_EN the same way as the design.
module tb_stream_mux_rr;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SEL_W = 2;

  logic                 clk;
  logic                 rst_n;
  logic [N-1:0]         in_valid;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_W-1:0]     out_sel;
  logic                 out_ready;

  int checks = 0;
  int errors = 0;

  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic [SEL_W-1:0] m_sel;
  int               m_last;

  stream_mux_rr #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef STREAM_MUX_FIXED_PRIO_EN
    for (int k = 0; k < N; k++)
      if (((v >> k) & N'(1)) != 0) return k;
    if (last < 0) return -1;
`else
    for (int k = 1; k <= N; k++)
      if (((v >> ((last + k) % N)) & N'(1)) != 0) return (last + k) % N;
`endif
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] chan(input logic [N*WIDTH-1:0] d, input int g);
    return WIDTH'(d >> (g * WIDTH));
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    g = pick(in_valid, m_last);
    if (rst_n && g >= 0 && (!m_valid || out_ready)) return N'(1) << g;
    return '0;
  endfunction

  // Reference model: the output register as a one-entry buffer fed by the arbiter's choice.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sel   <= '0;
      m_last  <= N - 1;
    end else if (!m_valid || out_ready) begin
      if (pick(in_valid, m_last) >= 0) begin
        m_valid <= 1'b1;
        m_data  <= chan(in_data, pick(in_valid, m_last));
        m_sel   <= SEL_W'(pick(in_valid, m_last));
        m_last  <= pick(in_valid, m_last);
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] er;
    er = exp_ready();
    checks++;
    if (in_ready !== er) begin
      errors++;
      $display("FAIL model_in_ready t=%0t: got %b expected %b", $time, in_ready, er);
    end
    checks++;
    if (out_valid !== m_valid) begin
      errors++;
      $display("FAIL model_out_valid t=%0t: got %b expected %b", $time, out_valid, m_valid);
    end
    checks++;
    if (out_data !== m_data) begin
      errors++;
      $display("FAIL model_out_data t=%0t: got %h expected %h", $time, out_data, m_data);
    end
    checks++;
    if (out_sel !== m_sel) begin
      errors++;
      $display("FAIL model_out_sel t=%0t: got %0d expected %0d", $time, out_sel, m_sel);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive inputs, check in_ready before the edge, return just after the edge.
  task automatic cyc(input logic [N-1:0] v, input logic rdy, input logic [N-1:0] erdy);
    in_valid  = v;
    out_ready = rdy;
    #1;
    check("in_ready", 32'(in_ready), 32'(erdy));
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [N-1:0] v, input logic rdy);
    in_valid  = v;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic out_is(input string name, input logic v, input logic [7:0] d, input int s);
    check({name, "_valid"}, 32'(out_valid), 32'(v));
    check({name, "_data"},  32'(out_data),  32'(d));
    check({name, "_sel"},   32'(out_sel),   32'(s));
  endtask

  typedef struct { logic [N-1:0] v; logic rdy; } vec_t;
  vec_t tbl[12];

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    out_is("reset", 1'b0, 8'h00, 0);
    rst_n = 1'b1;

    // Single active channel: granted every cycle, data appears one cycle later.
    in_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    cyc(4'b0100, 1'b1, 4'b0100);
    out_is("single1", 1'b1, 8'hA5, 2);
    cyc(4'b0100, 1'b1, 4'b0100);
    out_is("single2", 1'b1, 8'hA5, 2);
    cyc(4'b0100, 1'b1, 4'b0100);

    // Asynchronous reset while a word is held.
    #2 rst_n = 1'b0;
    #1;
    out_is("async_rst", 1'b0, 8'h00, 0);
    check("rst_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
`ifndef STREAM_MUX_FIXED_PRIO_EN
    cyc(4'b1111, 1'b1, 4'b0001);
    out_is("rr0", 1'b1, 8'h10, 0);
    cyc(4'b1111, 1'b1, 4'b0010);
    out_is("rr1", 1'b1, 8'h11, 1);
    cyc(4'b1111, 1'b1, 4'b0100);
    out_is("rr2", 1'b1, 8'h12, 2);
    cyc(4'b1111, 1'b1, 4'b1000);
    out_is("rr3", 1'b1, 8'h13, 3);
    cyc(4'b1111, 1'b1, 4'b0001);
    out_is("rr4", 1'b1, 8'h10, 0);

    for (int i = 0; i < 3; i++) begin
      cyc(4'b1111, 1'b0, 4'b0000);
      out_is("stall", 1'b1, 8'h10, 0);
    end
    cyc(4'b1111, 1'b1, 4'b0010);
    out_is("resume", 1'b1, 8'h11, 1);
    cyc(4'b0000, 1'b1, 4'b0000);
    out_is("drain", 1'b0, 8'h11, 1);

    cyc(4'b1000, 1'b1, 4'b1000);
    out_is("to_last3", 1'b1, 8'h13, 3);
    cyc(4'b0101, 1'b1, 4'b0001);
    out_is("wrap0", 1'b1, 8'h10, 0);
    cyc(4'b0101, 1'b1, 4'b0100);
    out_is("skip2", 1'b1, 8'h12, 2);
    cyc(4'b0101, 1'b1, 4'b0001);
    out_is("wrap0b", 1'b1, 8'h10, 0);
`else
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0110, 1'b1, 4'b0010);
      out_is("fixed", 1'b1, 8'h11, 1);
    end
    cyc(4'b0110, 1'b0, 4'b0000);
    out_is("fixed_stall", 1'b1, 8'h11, 1);
`endif

    tbl = '{'{4'b1011, 1'b1}, '{4'b1011, 1'b0}, '{4'b0000, 1'b0}, '{4'b1011, 1'b1},
            '{4'b0110, 1'b1}, '{4'b0001, 1'b0}, '{4'b0001, 1'b1}, '{4'b1111, 1'b1},
            '{4'b0000, 1'b1}, '{4'b0000, 1'b0}, '{4'b1001, 1'b1}, '{4'b1001, 1'b1}};
    for (int i = 0; i < 12; i++) begin
      in_data = 32'h11223344 + 32'(i) * 32'h01010101;
      drv(tbl[i].v, tbl[i].rdy);
    end
    drv(4'b0000, 1'b1);
    drv(4'b0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
